// File: rtl/klotski_seq_ctrl.sv
// Top-level Klotski solver sequencer: capture -> solve -> move -> verify loop with
// bounded motor retries, a per-wait watchdog, a move counter, abort and a latched error code.
module klotski_seq_ctrl #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int CELL_W    = 4,
  parameter int MAX_RETRY = 3,
  parameter int TMO_W     = 24,
  parameter int CNT_W     = 8
) (
  input  logic                          i_Clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_abort,
  output logic                          o_vga_start,
  input  logic                          i_vga_done,
  input  logic [ROWS*COLS*CELL_W-1:0]   i_board,
  input  logic [$clog2(ROWS)-1:0]       i_goal_row,
  input  logic [$clog2(COLS)-1:0]       i_goal_col,
  input  logic [CELL_W-1:0]             i_goal_id,
  output logic                          o_alg_start,
  output logic                          o_alg_continue,
  input  logic                          i_alg_move,
  input  logic                          i_alg_done,
  output logic                          o_bm_en,
  input  logic                          i_bm_done,
  output logic [ROWS*COLS*CELL_W-1:0]   o_board,
  output logic [CNT_W-1:0]              o_move_cnt,
  output logic                          o_done,
  output logic                          o_err,
  output logic [1:0]                    o_err_code,
  output logic [2:0]                    o_state
);

  localparam int BOARD_W = ROWS * COLS * CELL_W;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_ALGO    = 3'd2,
    S_MOTOR   = 3'd3,
    S_VERIFY  = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  // A goal coordinate outside the board (non power-of-two sizes) never matches.
  function automatic logic goal_match(input logic [BOARD_W-1:0] board,
                                      input logic [ROW_W-1:0]   row,
                                      input logic [COL_W-1:0]   col,
                                      input logic [CELL_W-1:0]  id);
    int                 idx;
    logic [BOARD_W-1:0] shifted;
    idx     = int'(row) * COLS + int'(col);
    shifted = board >> (idx * CELL_W);
    if (idx < ROWS * COLS) begin
      goal_match = (shifted[CELL_W-1:0] == id);
    end else begin
      goal_match = 1'b0;
    end
  endfunction

  state_t               state_q, state_d;
  logic [BOARD_W-1:0]   board_q, board_d;
  logic [CNT_W-1:0]     move_cnt_q, move_cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 first_q, first_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 alg_start_q, alg_start_d;
  logic                 alg_continue_q, alg_continue_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic                 vga_start_s;
  logic                 bm_en_s;
  logic [TMO_W-1:0]     tmo_inc_s;
  logic                 tmo_fire_s;
  logic                 waiting_s;

  // Watchdog fires on the cycle whose increment would make the counter all-ones.
  always_comb begin
    tmo_inc_s  = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
    tmo_fire_s = (tmo_inc_s == {TMO_W{1'b1}});
    waiting_s  = (state_q == S_CAPTURE) || (state_q == S_ALGO) ||
                 (state_q == S_MOTOR)   || (state_q == S_VERIFY);
  end

  // Next-state, handshake pulses and datapath updates.
  always_comb begin
    state_d        = state_q;
    board_d        = board_q;
    move_cnt_d     = move_cnt_q;
    retry_d        = retry_q;
    first_d        = first_q;
    alg_start_d    = 1'b0;
    alg_continue_d = 1'b0;
    done_d         = 1'b0;
    err_code_d     = err_code_q;
    vga_start_s    = 1'b0;
    bm_en_s        = 1'b0;

    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (i_start) begin
            vga_start_s = 1'b1;
            move_cnt_d  = {CNT_W{1'b0}};
            retry_d     = {RETRY_W{1'b0}};
            first_d     = 1'b1;
            err_code_d  = 2'd0;
            state_d     = S_CAPTURE;
          end else begin
            state_d = state_q;
          end
        end
        S_CAPTURE: begin
          if (i_vga_done) begin
            if (first_q) begin
              board_d = i_board;
            end else begin
              board_d = board_q;
            end
            first_d     = 1'b0;
            alg_start_d = 1'b1;
            state_d     = S_ALGO;
          end else if (tmo_fire_s) begin
            err_code_d = 2'd1;
            state_d    = S_ERROR;
          end else begin
            state_d = S_CAPTURE;
          end
        end
        S_ALGO: begin
          if (i_alg_done) begin
            state_d = S_DONE;
          end else if (i_alg_move) begin
            bm_en_s = 1'b1;
            retry_d = {RETRY_W{1'b0}};
            state_d = S_MOTOR;
          end else if (tmo_fire_s) begin
            err_code_d = 2'd1;
            state_d    = S_ERROR;
          end else begin
            state_d = S_ALGO;
          end
        end
        S_MOTOR: begin
          if (i_bm_done) begin
            vga_start_s = 1'b1;
            state_d     = S_VERIFY;
          end else if (tmo_fire_s) begin
            err_code_d = 2'd1;
            state_d    = S_ERROR;
          end else begin
            state_d = S_MOTOR;
          end
        end
        S_VERIFY: begin
          if (i_vga_done) begin
            if (goal_match(i_board, i_goal_row, i_goal_col, i_goal_id)) begin
              alg_continue_d = 1'b1;
              if (move_cnt_q != {CNT_W{1'b1}}) begin
                move_cnt_d = move_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
              end else begin
                move_cnt_d = move_cnt_q;
              end
              state_d = S_ALGO;
            end else if (retry_q < RETRY_W'(MAX_RETRY - 1)) begin
              retry_d = retry_q + {{(RETRY_W-1){1'b0}}, 1'b1};
              bm_en_s = 1'b1;
              state_d = S_MOTOR;
            end else begin
              err_code_d = 2'd2;
              state_d    = S_ERROR;
            end
          end else if (tmo_fire_s) begin
            err_code_d = 2'd1;
            state_d    = S_ERROR;
          end else begin
            state_d = S_VERIFY;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Watchdog restarts on every state change and only advances while waiting on a peer.
  always_comb begin
    err_d = (state_d == S_ERROR);
    if (state_d != state_q) begin
      tmo_d = {TMO_W{1'b0}};
    end else if (waiting_s) begin
      tmo_d = tmo_inc_s;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      board_q        <= {BOARD_W{1'b0}};
      move_cnt_q     <= {CNT_W{1'b0}};
      retry_q        <= {RETRY_W{1'b0}};
      first_q        <= 1'b0;
      tmo_q          <= {TMO_W{1'b0}};
      alg_start_q    <= 1'b0;
      alg_continue_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      err_code_q     <= 2'd0;
    end else begin
      state_q        <= state_d;
      board_q        <= board_d;
      move_cnt_q     <= move_cnt_d;
      retry_q        <= retry_d;
      first_q        <= first_d;
      tmo_q          <= tmo_d;
      alg_start_q    <= alg_start_d;
      alg_continue_q <= alg_continue_d;
      done_q         <= done_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
    end
  end

  assign o_vga_start    = vga_start_s;
  assign o_bm_en        = bm_en_s;
  assign o_alg_start    = alg_start_q;
  assign o_alg_continue = alg_continue_q;
  assign o_board        = board_q;
  assign o_move_cnt     = move_cnt_q;
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_err_code     = err_code_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_klotski_seq_ctrl.sv
// Directed bench for klotski_seq_ctrl (4x4 board, 4-bit watchdog): nominal run, retries,
// retry exhaustion, watchdog timeout, move/done priority, abort and mid-run reset.
module tb_klotski_seq_ctrl;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_abort, i_vga_done, i_alg_move, i_alg_done, i_bm_done;
  logic [63:0] i_board;
  logic [1:0]  i_goal_row, i_goal_col;
  logic [3:0]  i_goal_id;
  logic        o_vga_start, o_alg_start, o_alg_continue, o_bm_en, o_done, o_err;
  logic [63:0] o_board;
  logic [7:0]  o_move_cnt;
  logic [1:0]  o_err_code;
  logic [2:0]  o_state;

  int errors = 0;
  int checks = 0;
  int n_bm   = 0;
  int n_done = 0;
  int ev_log[$];

  always #5 clk = ~clk;

  klotski_seq_ctrl #(.ROWS(4), .COLS(4), .CELL_W(4), .MAX_RETRY(3), .TMO_W(4), .CNT_W(8)) dut (
    .i_Clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .o_vga_start(o_vga_start), .i_vga_done(i_vga_done), .i_board(i_board),
    .i_goal_row(i_goal_row), .i_goal_col(i_goal_col), .i_goal_id(i_goal_id),
    .o_alg_start(o_alg_start), .o_alg_continue(o_alg_continue),
    .i_alg_move(i_alg_move), .i_alg_done(i_alg_done),
    .o_bm_en(o_bm_en), .i_bm_done(i_bm_done), .o_board(o_board),
    .o_move_cnt(o_move_cnt), .o_done(o_done), .o_err(o_err),
    .o_err_code(o_err_code), .o_state(o_state)
  );

  // Pulse log: 1=vga_start 2=alg_start 3=bm_en 4=alg_continue 5=done
  always @(posedge clk) begin
    if (o_vga_start)    ev_log.push_back(1);
    if (o_alg_start)    ev_log.push_back(2);
    if (o_bm_en) begin
      ev_log.push_back(3);
      n_bm++;
    end
    if (o_alg_continue) ev_log.push_back(4);
    if (o_done) begin
      ev_log.push_back(5);
      n_done++;
    end
  end

  function automatic logic [63:0] make_board(input logic [3:0] goal_val);
    logic [63:0] b;
    for (int i = 0; i < 16; i++) b[i*4 +: 4] = 4'(i);
    b[13*4 +: 4] = goal_val;
    return b;
  endfunction

  logic [63:0] b_start, b_ok, b_bad;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_vga_done = 1'b0;
    i_alg_move = 1'b0; i_alg_done = 1'b0; i_bm_done = 1'b0; i_board = 64'd0;
    tick; tick;
    i_rst = 1'b0;
  endtask

  task automatic do_start;
    i_start = 1'b1; tick; i_start = 1'b0;
  endtask

  task automatic do_capture(input logic [63:0] b);
    i_board = b; i_vga_done = 1'b1; tick; i_vga_done = 1'b0;
  endtask

  task automatic do_move;
    i_alg_move = 1'b1; tick; i_alg_move = 1'b0;
  endtask

  task automatic do_bm_done;
    i_bm_done = 1'b1; tick; i_bm_done = 1'b0;
  endtask

  task automatic test_reset;
    reset_dut;
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", o_state); end
    checks++; if ({o_vga_start, o_alg_start, o_alg_continue, o_bm_en, o_done, o_err} !== 6'd0) begin
      errors++; $display("FAIL reset_pulses: got %b want 000000", {o_vga_start, o_alg_start, o_alg_continue, o_bm_en, o_done, o_err}); end
    checks++; if (o_board !== 64'd0 || o_move_cnt !== 8'd0 || o_err_code !== 2'd0) begin
      errors++; $display("FAIL reset_data: board=%h cnt=%0d code=%0d want 0/0/0", o_board, o_move_cnt, o_err_code); end
  endtask

  task automatic test_nominal;
    int base;
    int exp_ev[9] = '{1, 2, 3, 1, 4, 3, 1, 4, 5};
    reset_dut;
    base = ev_log.size();
    i_start = 1'b1; #1;
    checks++; if (o_vga_start !== 1'b1) begin errors++; $display("FAIL nom_vga_start: got %b want 1", o_vga_start); end
    tick; i_start = 1'b0;
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL nom_capture_state: got %0d want 1", o_state); end
    do_capture(b_start);
    checks++; if (o_state !== 3'd2 || o_alg_start !== 1'b1) begin
      errors++; $display("FAIL nom_alg_start: state=%0d alg_start=%b want 2/1", o_state, o_alg_start); end
    checks++; if (o_board !== b_start) begin errors++; $display("FAIL nom_board: got %h want %h", o_board, b_start); end
    tick;
    checks++; if (o_alg_start !== 1'b0) begin errors++; $display("FAIL nom_alg_start_width: got %b want 0", o_alg_start); end
    for (int m = 1; m <= 2; m++) begin
      do_move;
      do_bm_done;
      checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL nom_verify_state: got %0d want 4", o_state); end
      do_capture(b_ok);
      checks++; if (o_state !== 3'd2 || o_alg_continue !== 1'b1 || o_move_cnt !== 8'(m)) begin
        errors++; $display("FAIL nom_move_ok: state=%0d cont=%b cnt=%0d want 2/1/%0d", o_state, o_alg_continue, o_move_cnt, m); end
      tick;
    end
    i_alg_done = 1'b1; tick; i_alg_done = 1'b0;
    checks++; if (o_state !== 3'd5) begin errors++; $display("FAIL nom_done_state: got %0d want 5", o_state); end
    tick;
    checks++; if (o_state !== 3'd0 || o_done !== 1'b1 || o_move_cnt !== 8'd2) begin
      errors++; $display("FAIL nom_done: state=%0d done=%b cnt=%0d want 0/1/2", o_state, o_done, o_move_cnt); end
    checks++; if (o_board !== b_start) begin errors++; $display("FAIL nom_board_held: got %h want %h", o_board, b_start); end
    tick;
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL nom_done_width: got %b want 0", o_done); end
    checks++; if (ev_log.size() - base !== 9) begin
      errors++; $display("FAIL nom_pulse_count: got %0d want 9", ev_log.size() - base); end
    else begin
      for (int k = 0; k < 9; k++) begin
        checks++; if (ev_log[base + k] !== exp_ev[k]) begin
          errors++; $display("FAIL nom_pulse_seq[%0d]: got %0d want %0d", k, ev_log[base + k], exp_ev[k]); end
      end
    end
  endtask

  task automatic test_reset_mid_run;
    reset_dut;
    do_start; do_capture(b_start); tick;
    do_move; do_bm_done; do_capture(b_ok); tick;
    do_move;
    checks++; if (o_state !== 3'd3 || o_move_cnt !== 8'd1) begin
      errors++; $display("FAIL rst_setup: state=%0d cnt=%0d want 3/1", o_state, o_move_cnt); end
    i_rst = 1'b1; tick; i_rst = 1'b0;
    checks++; if (o_state !== 3'd0 || o_move_cnt !== 8'd0 || o_err !== 1'b0 || o_board !== 64'd0) begin
      errors++; $display("FAIL rst_mid_run: state=%0d cnt=%0d err=%b board=%h want 0/0/0/0", o_state, o_move_cnt, o_err, o_board); end
    checks++; if ({o_vga_start, o_alg_start, o_alg_continue, o_bm_en, o_done} !== 5'd0) begin
      errors++; $display("FAIL rst_mid_pulses: got %b want 00000", {o_vga_start, o_alg_start, o_alg_continue, o_bm_en, o_done}); end
  endtask

  task automatic test_retry;
    int base;
    reset_dut;
    do_start; do_capture(b_start); tick;
    base = n_bm;
    do_move;
    for (int r = 0; r < 2; r++) begin
      do_bm_done; do_capture(b_bad);
      checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL retry_reissue%0d: state=%0d want 3", r, o_state); end
    end
    do_bm_done; do_capture(b_ok);
    checks++; if (o_state !== 3'd2 || o_move_cnt !== 8'd1) begin
      errors++; $display("FAIL retry_recover: state=%0d cnt=%0d want 2/1", o_state, o_move_cnt); end
    checks++; if (n_bm - base !== 3) begin errors++; $display("FAIL retry_bm_count: got %0d want 3", n_bm - base); end
  endtask

  task automatic test_retry_exhaust;
    reset_dut;
    do_start; do_capture(b_start); tick; do_move;
    for (int r = 0; r < 3; r++) begin
      do_bm_done; do_capture(b_bad);
    end
    checks++; if (o_state !== 3'd6 || o_err !== 1'b1 || o_err_code !== 2'd2) begin
      errors++; $display("FAIL exhaust_error: state=%0d err=%b code=%0d want 6/1/2", o_state, o_err, o_err_code); end
    tick;
    checks++; if (o_state !== 3'd6 || o_err_code !== 2'd2) begin
      errors++; $display("FAIL exhaust_hold: state=%0d code=%0d want 6/2", o_state, o_err_code); end
    i_start = 1'b1; #1;
    checks++; if (o_vga_start !== 1'b1) begin errors++; $display("FAIL exhaust_restart_vga: got %b want 1", o_vga_start); end
    tick; i_start = 1'b0;
    checks++; if (o_state !== 3'd1 || o_err !== 1'b0 || o_err_code !== 2'd0) begin
      errors++; $display("FAIL exhaust_restart: state=%0d err=%b code=%0d want 1/0/0", o_state, o_err, o_err_code); end
  endtask

  task automatic test_timeout;
    int n;
    reset_dut;
    do_start; do_capture(b_start); tick; do_move;
    n = 0;
    while (o_state === 3'd3 && n < 40) begin
      n++;
      tick;
    end
    checks++; if (n !== 15) begin errors++; $display("FAIL tmo_cycles: got %0d want 15", n); end
    checks++; if (o_state !== 3'd6 || o_err !== 1'b1 || o_err_code !== 2'd1) begin
      errors++; $display("FAIL tmo_error: state=%0d err=%b code=%0d want 6/1/1", o_state, o_err, o_err_code); end
  endtask

  task automatic test_move_done_priority;
    reset_dut;
    do_start; do_capture(b_start); tick;
    i_alg_move = 1'b1; i_alg_done = 1'b1; #1;
    checks++; if (o_bm_en !== 1'b0) begin errors++; $display("FAIL prio_bm_en: got %b want 0", o_bm_en); end
    tick; i_alg_move = 1'b0; i_alg_done = 1'b0;
    checks++; if (o_state !== 3'd5) begin errors++; $display("FAIL prio_state: got %0d want 5", o_state); end
    tick;
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL prio_done: got %b want 1", o_done); end
  endtask

  task automatic test_abort;
    int base;
    reset_dut;
    do_start; do_capture(b_start); tick; do_move; do_bm_done;
    checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL abort_setup: state=%0d want 4", o_state); end
    base = n_done;
    i_abort = 1'b1; tick; i_abort = 1'b0;
    checks++; if (o_state !== 3'd0 || o_err !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: state=%0d err=%b done=%b want 0/0/0", o_state, o_err, o_done); end
    tick; tick;
    checks++; if (n_done - base !== 0 || o_err !== 1'b0 || o_err_code !== 2'd0) begin
      errors++; $display("FAIL abort_quiet: dones=%0d err=%b code=%0d want 0/0/0", n_done - base, o_err, o_err_code); end
  endtask

  initial begin
    b_start    = make_board(4'd7);
    b_ok       = make_board(4'd1);
    b_bad      = make_board(4'd2);
    i_goal_row = 2'd3;
    i_goal_col = 2'd1;
    i_goal_id  = 4'd1;
    test_reset;
    test_nominal;
    test_reset_mid_run;
    test_retry;
    test_retry_exhaust;
    test_timeout;
    test_move_done_priority;
    test_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
